data_mem_bytelane: RTL and testbench

DATA_MEM_BYTELANE -- requirements
Module: data_mem_bytelane

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_lane_align.sv | 70 +++++++
 rtl/data_mem_bytelane.sv | 203 ++++++++++++++++++++
 tb/tb_data_mem_bytelane.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared definitions for the byte-lane data memory: access
//                size encodings and the access FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Access size encodings carried on the size port
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  // Access FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational byte-lane steering for a 32-bit little-endian
//                word. Produces the store lane mask and lane-replicated
//                store data, and extracts/extends load data.
//  Ports       : i_size     - access size encoding
//                i_off      - byte offset within the word (A[1:0])
//                i_unsigned - 1 = zero-extend sub-word loads
//                i_wd       - right-aligned store data
//                i_rword    - memory word being read
//                o_wmask    - per-lane write enables (lane 0 = bits 7:0)
//                o_wdata    - store data placed on the addressed lanes
//                o_rdata    - extracted and extended load data
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  input  logic [31:0] i_wd,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;

  // Bring the addressed byte/half down to bit 0 for extraction
  assign w_shifted = i_rword >> {i_off, 3'b000};

  // Store data is replicated across the word so whichever lanes the mask
  // enables already hold the right bytes; no data shifter is needed.
  always_comb begin
    o_wmask = 4'b0000;
    o_wdata = '0;
    case (i_size)
      SZ_BYTE: begin
        o_wmask = 4'b0001 << i_off;
        o_wdata = {4{i_wd[7:0]}};
      end
      SZ_HALF: begin
        o_wmask = 4'b0011 << i_off;
        o_wdata = {2{i_wd[15:0]}};
      end
      SZ_WORD: begin
        o_wmask = 4'b1111;
        o_wdata = i_wd;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_rdata = '0;
    case (i_size)
      SZ_BYTE: o_rdata = i_unsigned ? {24'd0, w_shifted[7:0]}
                                    : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_rdata = i_unsigned ? {16'd0, w_shifted[15:0]}
                                    : {{16{w_shifted[15]}}, w_shifted[15:0]};
      SZ_WORD: o_rdata = i_rword;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_bytelane.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_bytelane
//  Description : Word-organised data memory with byte/half/word access,
//                sign/zero-extended loads, misalignment/range error
//                detection and a configurable number of wait states.
//  Ports       : clk, rst (async, active low)
//                req/WE/size/unsigned_ld/A/WD - request, sampled in IDLE
//                RD/err      - response data/error, held until next response
//                ready       - one-cycle response strobe
//                test_value  - live view of word 0 bits [15:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_bytelane
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    WE,
  input  logic [1:0]              size,
  input  logic                    unsigned_ld,
  input  logic [ADDR_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   WD,
  output logic [DATA_WIDTH-1:0]   RD,
  output logic                    ready,
  output logic                    err,
  output logic [DATA_WIDTH/2-1:0] test_value
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-2:0] DEPTH_LIM = (ADDR_WIDTH-1)'(DEPTH);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

  // ---------------------------------------------------------------- state
  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [1:0]              off_q, off_d;
  logic [DATA_WIDTH-1:0]   wd_q, wd_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic                    rerr_q, rerr_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rd_q, rd_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    w_in_oob;
  logic                    w_in_err;
  logic                    w_mem_wr;
  logic [3:0]              w_wmask;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [DATA_WIDTH-1:0]   w_load;

  // --------------------------------------------------- request validation
  assign w_in_oob = {1'b0, A[ADDR_WIDTH-1:2]} >= DEPTH_LIM;

  always_comb begin
    case (size)
      SZ_BYTE: w_in_err = w_in_oob;
      SZ_HALF: w_in_err = w_in_oob | A[0];
      SZ_WORD: w_in_err = w_in_oob | (A[1:0] != 2'b00);
      default: w_in_err = 1'b1;
    endcase
  end

  // ------------------------------------------------------ request capture
  // The *_d request values are what the access uses on the edge entering
  // RESP; when RESP is entered straight from IDLE they are the live inputs.
  always_comb begin
    idx_d  = idx_q;
    off_d  = off_q;
    wd_d   = wd_q;
    we_d   = we_q;
    size_d = size_q;
    uns_d  = uns_q;
    rerr_d = rerr_q;
    if (state_q == ST_IDLE && req) begin
      idx_d  = A[IDX_W+1:2];
      off_d  = A[1:0];
      wd_d   = WD;
      we_d   = WE;
      size_d = size;
      uns_d  = unsigned_ld;
      rerr_d = w_in_err;
    end
  end

  dmem_lane_align u_align (
    .i_size     (size_d),
    .i_off      (off_d),
    .i_unsigned (uns_d),
    .i_wd       (wd_d),
    .i_rword    (mem_q[idx_d]),
    .o_wmask    (w_wmask),
    .o_wdata    (w_wdata),
    .o_rdata    (w_load)
  );

  // ------------------------------------------------------- FSM next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    rd_d     = rd_q;
    err_d    = err_q;
    w_mem_wr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if ((WAIT_STATES == 0) || w_in_err) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      // ready is registered, so it is seen in the cycle after RESP
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Memory access and response capture on the edge entering RESP
    if (state_d == ST_RESP && state_q != ST_RESP) begin
      if (rerr_d) begin
        rd_d  = '0;
        err_d = 1'b1;
      end else if (we_d) begin
        rd_d     = '0;
        err_d    = 1'b0;
        w_mem_wr = 1'b1;
      end else begin
        rd_d  = w_load;
        err_d = 1'b0;
      end
    end
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      wd_q    <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      rerr_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rerr_q  <= rerr_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  // Storage array: written lane-by-lane under the mask rather than through
  // a full-word _d copy, so untouched lanes keep their contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (w_mem_wr) begin
      for (int l = 0; l < 4; l++) begin
        if (w_wmask[l]) mem_q[idx_d][8*l +: 8] <= w_wdata[8*l +: 8];
      end
    end
  end

  assign RD         = rd_q;
  assign ready      = ready_q;
  assign err        = err_q;
  assign test_value = mem_q[0][DATA_WIDTH/2-1:0];

endmodule
`default_nettype wire

// File: tb/tb_data_mem_bytelane.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_bytelane
//  Description : Self-checking bench for data_mem_bytelane. Instance u_dut
//                uses 1 wait state; u_dut3 uses 3 wait states for the
//                reset-abort scenario. Expected data comes from a byte-array
//                model of the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_bytelane;

  localparam int DEPTH  = 64;
  localparam int DEPTH3 = 16;
  localparam int WS     = 1;
  localparam int WS3    = 3;

  logic        clk = 1'b0;
  logic        rst, rst3, req, req3, WE, unsigned_ld;
  logic [1:0]  size;
  logic [31:0] A, WD;
  logic [31:0] RD, RD3;
  logic        ready, err, ready3, err3;
  logic [15:0] test_value, test_value3;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mb [DEPTH*4];

  always #5 clk = ~clk;

  data_mem_bytelane #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst(rst), .req(req), .WE(WE), .size(size), .unsigned_ld(unsigned_ld),
    .A(A), .WD(WD), .RD(RD), .ready(ready), .err(err), .test_value(test_value)
  );

  data_mem_bytelane #(.DATA_WIDTH(32), .DEPTH(DEPTH3), .ADDR_WIDTH(32), .WAIT_STATES(WS3)) u_dut3 (
    .clk(clk), .rst(rst3), .req(req3), .WE(WE), .size(size), .unsigned_ld(unsigned_ld),
    .A(A), .WD(WD), .RD(RD3), .ready(ready3), .err(err3), .test_value(test_value3)
  );

  // ---------------------------------------------------------- reference
  function automatic void model_clear();
    for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
  endfunction

  function automatic void model_access(input bit we, input logic [1:0] sz, input bit uns,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] rd, output bit e);
    int n;
    logic [63:0] v;
    n  = 1 << sz;
    e  = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)
         || ((addr >> 2) >= DEPTH);
    rd = 32'd0;
    if (e) return;
    if (we) begin
      for (int i = 0; i < n; i++) mb[addr+i] = wd[8*i +: 8];
    end else begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v = v | (64'(mb[addr+i]) << (8*i));
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      rd = v[31:0];
    end
  endfunction

  function automatic logic [15:0] model_tv();
    return {mb[1], mb[0]};
  endfunction

  // ---------------------------------------------------------- stimulus
  // Issues one request, scrambles the inputs once it is accepted, and
  // reports what came back plus whether ready dropped the following cycle.
  task automatic access(input bit which, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd_o, output bit err_o, output int lat,
                        output bit strobe_ok, output logic [31:0] exp_rd, output bit exp_err);
    WE = we; size = sz; unsigned_ld = uns; A = addr; WD = wd;
    if (which) req3 = 1'b1; else req = 1'b1;
    exp_rd = 32'd0; exp_err = 1'b0;
    if (!which) model_access(we, sz, uns, addr, wd, exp_rd, exp_err);
    @(posedge clk); #1;
    req = 1'b0; req3 = 1'b0;
    WE = 1'($urandom); size = 2'($urandom); unsigned_ld = 1'($urandom);
    A = $urandom; WD = $urandom;
    lat = -1; rd_o = 32'hx; err_o = 1'bx; strobe_ok = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if ((which ? ready3 : ready) === 1'b1) begin
        lat = c; rd_o = which ? RD3 : RD; err_o = which ? err3 : err;
        break;
      end
    end
    @(posedge clk); #1;
    strobe_ok = ((which ? ready3 : ready) === 1'b0);
  endtask

  // ------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b0; rst3 = 1'b0; req = 1'b0; req3 = 1'b0;
    WE = 1'b0; size = 2'b00; unsigned_ld = 1'b0; A = 32'd0; WD = 32'd0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", ready); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL rst_err got=%b exp=0", err); else n_pass++;
    n_checks++; if (RD !== 32'd0) $display("FAIL rst_rd got=%h exp=0", RD); else n_pass++;
    n_checks++; if (test_value !== 16'd0) $display("FAIL rst_tv got=%h exp=0", test_value); else n_pass++;
    n_checks++; if (ready3 !== 1'b0) $display("FAIL rst_ready3 got=%b exp=0", ready3); else n_pass++;
    rst = 1'b1; rst3 = 1'b1;
  endtask

  task automatic test_word_roundtrip();
    logic [31:0] r, er; bit e, ee, s; int lat;
    access(0, 1, 2'b10, 0, 32'h8, 32'hDEADBEEF, r, e, lat, s, er, ee);
    n_checks++; if (lat !== 1+WS) $display("FAIL rt_st_lat got=%0d exp=%0d", lat, 1+WS); else n_pass++;
    n_checks++; if (r !== 32'd0 || e !== 1'b0) $display("FAIL rt_st_resp got=%h/%b exp=0/0", r, e); else n_pass++;
    access(0, 0, 2'b10, 0, 32'h8, 32'h0, r, e, lat, s, er, ee);
    n_checks++; if (r !== 32'hDEADBEEF) $display("FAIL rt_ld_rd got=%h exp=deadbeef", r); else n_pass++;
    n_checks++; if (e !== 1'b0) $display("FAIL rt_ld_err got=%b exp=0", e); else n_pass++;
    n_checks++; if (lat !== 1+WS) $display("FAIL rt_ld_lat got=%0d exp=%0d", lat, 1+WS); else n_pass++;
    n_checks++; if (s !== 1'b1) $display("FAIL rt_strobe got=%b exp=1", s); else n_pass++;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r, er; bit e, ee, s; int lat;
    access(0, 1, 2'b10, 0, 32'h10, 32'h11223344, r, e, lat, s, er, ee);
    access(0, 1, 2'b00, 0, 32'h12, 32'hFFFFFFAA, r, e, lat, s, er, ee);
    access(0, 0, 2'b00, 0, 32'h12, 32'h0, r, e, lat, s, er, ee);
    n_checks++; if (r !== 32'hFFFFFFAA) $display("FAIL sbyte_rd got=%h exp=ffffffaa", r); else n_pass++;
    access(0, 0, 2'b00, 1, 32'h12, 32'h0, r, e, lat, s, er, ee);
    n_checks++; if (r !== 32'h000000AA) $display("FAIL ubyte_rd got=%h exp=000000aa", r); else n_pass++;
    access(0, 0, 2'b10, 1, 32'h10, 32'h0, r, e, lat, s, er, ee);
    n_checks++; if (r !== 32'h11AA3344) $display("FAIL lanes_word got=%h exp=11aa3344", r); else n_pass++;
  endtask

  task automatic test_halfword();
    logic [31:0] r, er; bit e, ee, s; int lat;
    access(0, 1, 2'b01, 0, 32'h20, 32'h00008001, r, e, lat, s, er, ee);
    access(0, 0, 2'b01, 0, 32'h20, 32'h0, r, e, lat, s, er, ee);
    n_checks++; if (r !== 32'hFFFF8001) $display("FAIL shalf_rd got=%h exp=ffff8001", r); else n_pass++;
    access(0, 0, 2'b01, 1, 32'h20, 32'h0, r, e, lat, s, er, ee);
    n_checks++; if (r !== 32'h00008001) $display("FAIL uhalf_rd got=%h exp=00008001", r); else n_pass++;
  endtask

  task automatic test_errors();
    logic [31:0] r, er; bit e, ee, s; int lat;
    access(0, 1, 2'b10, 0, 32'h4, 32'h0BADF00D, r, e, lat, s, er, ee);
    access(0, 1, 2'b10, 0, 32'h6, 32'h12345678, r, e, lat, s, er, ee);
    n_checks++; if (e !== 1'b1 || lat !== 1) $display("FAIL err_wmis got=%b/%0d exp=1/1", e, lat); else n_pass++;
    access(0, 0, 2'b10, 0, 32'h4, 32'h0, r, e, lat, s, er, ee);
    n_checks++; if (r !== 32'h0BADF00D) $display("FAIL err_unchanged got=%h exp=0badf00d", r); else n_pass++;
    access(0, 0, 2'b01, 0, 32'h3, 32'h0, r, e, lat, s, er, ee);
    n_checks++; if (e !== 1'b1 || r !== 32'd0 || lat !== 1) $display("FAIL err_hmis got=%b/%h/%0d exp=1/0/1", e, r, lat); else n_pass++;
    access(0, 0, 2'b11, 0, 32'h8, 32'h0, r, e, lat, s, er, ee);
    n_checks++; if (e !== 1'b1 || r !== 32'd0 || lat !== 1) $display("FAIL err_size got=%b/%h/%0d exp=1/0/1", e, r, lat); else n_pass++;
    access(0, 0, 2'b10, 0, DEPTH*4, 32'h0, r, e, lat, s, er, ee);
    n_checks++; if (e !== 1'b1 || lat !== 1) $display("FAIL err_oob got=%b/%0d exp=1/1", e, lat); else n_pass++;
    n_checks++; if (s !== 1'b1) $display("FAIL err_strobe got=%b exp=1", s); else n_pass++;
  endtask

  task automatic test_test_value();
    logic [31:0] r, er; bit e, ee, s; int lat;
    access(0, 1, 2'b01, 0, 32'h0, 32'h0000BEEF, r, e, lat, s, er, ee);
    n_checks++; if (test_value !== 16'hBEEF) $display("FAIL tv_half got=%h exp=beef", test_value); else n_pass++;
    access(0, 1, 2'b00, 0, 32'h3, 32'h0000007E, r, e, lat, s, er, ee);
    n_checks++; if (test_value !== model_tv()) $display("FAIL tv_lane3 got=%h exp=%h", test_value, model_tv()); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    logic [31:0] r, er, dummy; bit e, ee, s, de; int lat, pulses;
    WE = 1'b1; size = 2'b10; unsigned_ld = 1'b0; A = 32'h30; WD = 32'hCAFEF00D; req = 1'b1;
    model_access(1, 2'b10, 0, 32'h30, 32'hCAFEF00D, dummy, de);
    @(posedge clk); #1;
    // Second request while the first is still waiting
    A = 32'h34; WD = 32'h12345678; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (ready === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    n_checks++; if (pulses !== 1) $display("FAIL busy_pulses got=%0d exp=1", pulses); else n_pass++;
    access(0, 0, 2'b10, 0, 32'h34, 32'h0, r, e, lat, s, er, ee);
    n_checks++; if (r !== er) $display("FAIL busy_second got=%h exp=%h", r, er); else n_pass++;
    access(0, 0, 2'b10, 0, 32'h30, 32'h0, r, e, lat, s, er, ee);
    n_checks++; if (r !== 32'hCAFEF00D) $display("FAIL busy_first got=%h exp=cafef00d", r); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] r, er, addr, wd; bit e, ee, s, we, uns; logic [1:0] sz; int lat, bad;
    bad = 0;
    for (int t = 0; t < 150; t++) begin
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = $urandom_range(0, DEPTH*4 + 7);
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      if (sz != 2'b11 && $urandom_range(0, 4) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      wd = $urandom;
      access(0, we, sz, uns, addr, wd, r, e, lat, s, er, ee);
      n_checks++;
      if (r !== er || e !== ee || lat !== (ee ? 1 : 1+WS) || s !== 1'b1 || test_value !== model_tv()) begin
        $display("FAIL rand_%0d a=%h sz=%0d we=%b got=%h/%b/%0d exp=%h/%b/%0d", t, addr, sz, we, r, e, lat, er, ee, ee ? 1 : 1+WS);
        bad++;
      end else n_pass++;
    end
  endtask

  task automatic test_reset_clears();
    logic [31:0] r, er, addr; bit e, ee, s; int lat, bad;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    rst = 1'b1;
    n_checks++; if (test_value !== 16'd0) $display("FAIL clr_tv got=%h exp=0", test_value); else n_pass++;
    bad = 0;
    for (int t = 0; t < 12; t++) begin
      addr = (t < 4) ? 32'(t*4 + 8) : 32'($urandom_range(0, DEPTH-1) * 4);
      access(0, 0, 2'b10, 0, addr, 32'h0, r, e, lat, s, er, ee);
      if (r !== er) begin
        $display("FAIL clr_word a=%h got=%h exp=%h", addr, r, er);
        bad++;
      end
    end
    n_checks++; if (bad != 0) $display("FAIL clr_words got=%0d bad exp=0", bad); else n_pass++;
  endtask

  task automatic test_reset_midaccess();
    logic [31:0] r, er; bit e, ee, s; int lat, pulses;
    access(1, 1, 2'b10, 0, 32'h0, 32'h0000A5A5, r, e, lat, s, er, ee);
    n_checks++; if (lat !== 1+WS3) $display("FAIL ws3_lat got=%0d exp=%0d", lat, 1+WS3); else n_pass++;
    n_checks++; if (test_value3 !== 16'hA5A5) $display("FAIL ws3_tv got=%h exp=a5a5", test_value3); else n_pass++;
    WE = 1'b1; size = 2'b10; A = 32'h0; WD = 32'h00000055; req3 = 1'b1;
    @(posedge clk); #1;
    req3 = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) rst3 = 1'b1;
      @(posedge clk); #1;
      if (ready3 === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) $display("FAIL abort_pulses got=%0d exp=0", pulses); else n_pass++;
    n_checks++; if (test_value3 !== 16'd0) $display("FAIL abort_tv got=%h exp=0", test_value3); else n_pass++;
    access(1, 0, 2'b10, 0, 32'h0, 32'h0, r, e, lat, s, er, ee);
    n_checks++; if (r !== 32'd0 || e !== 1'b0) $display("FAIL abort_word0 got=%h/%b exp=0/0", r, e); else n_pass++;
    n_checks++; if (lat !== 1+WS3) $display("FAIL abort_lat got=%0d exp=%0d", lat, 1+WS3); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_word_roundtrip();
    test_byte_lanes();
    test_halfword();
    test_errors();
    test_test_value();
    test_busy_ignore();
    test_random();
    test_reset_clears();
    test_reset_midaccess();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
